// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl
//   Reaction-time game controller. It sits directly upstream of an 8-bit up
//   counter and drives that counter's Enable and Reset inputs.
//   A Start begins a pseudo-random wait. When the wait ends, Led lights and the
//   counter gets one Enable pulse per tick. The player's Button press freezes the
//   count and latches it as Result.
//   A press before Led is a false start. If the counter reaches 8'hFF before a
//   press, the game ends as a timeout.
//
//   Optional feature macro: BEST_TIME_EN
//     When defined, BestTime tracks the minimum valid Result since Reset.
//     When undefined, BestTime is tied to 8'hFF.
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   synchronous active-high reset
//   Start        in   start / restart request (honoured in IDLE, DONE, FAULT)
//   Button       in   asynchronous player button, active-high
//   CountIn      in   [7:0] current value of the downstream counter
//   CountEnable  out  one-cycle Enable pulse per tick while in GO
//   CountReset   out  clear to the downstream counter
//   Led          out  "react now" indicator
//   Result       out  [7:0] latched reaction time in ticks
//   ResultValid  out  high while in DONE
//   FalseStart   out  high while in FAULT
//   Timeout      out  DONE was reached by counter saturation
//   BestTime     out  [7:0] best valid result since Reset
module reaction_timer_ctrl #(
  parameter int TICK_DIV        = 50000,
  parameter int DELAY_MIN_TICKS = 1000,
  parameter int RAND_BITS       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Button,
  input  logic [7:0] CountIn,
  output logic       CountEnable,
  output logic       CountReset,
  output logic       Led,
  output logic [7:0] Result,
  output logic       ResultValid,
  output logic       FalseStart,
  output logic       Timeout,
  output logic [7:0] BestTime
);
  localparam int PW = $clog2(TICK_DIV);
  // Holds DELAY_MIN_TICKS (16-bit) plus up to 8 random bits without overflow.
  localparam int DW = 17;

  typedef enum logic [2:0] {IDLE, ARMED, GO, DONE, FAULT} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [7:0]      lfsr;
  logic [DW-1:0]   delay;
  logic            btn_s1, btn_s2, btn_s3, btn_edge;
  logic            load_delay, dec_delay, latch_result, set_timeout;
  logic [7:0]      result_next;

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign btn_edge = btn_s2 & ~btn_s3;

  // Two flops synchronise Button; the third remembers the last level for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= Button;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  // The LFSR free-runs every clock, so the delay depends on when Start arrives.
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Clearing on each state change makes the first tick in every state a full period away.
  always_ff @(posedge Clock) begin
    if (Reset)                              presc <= '0;
    else if (state_next != state || tick)   presc <= '0;
    else                                    presc <= presc + PW'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset)           delay <= '0;
    else if (load_delay) delay <= DW'(DELAY_MIN_TICKS) + DW'(lfsr[RAND_BITS-1:0]);
    else if (dec_delay)  delay <= delay - DW'(1);
  end

  always_comb begin
    state_next   = state;
    load_delay   = 1'b0;
    dec_delay    = 1'b0;
    latch_result = 1'b0;
    set_timeout  = 1'b0;
    result_next  = 8'h00;
    case (state)
      IDLE, DONE, FAULT: begin
        if (Start) begin
          state_next = ARMED;
          load_delay = 1'b1;
        end
      end
      ARMED: begin
        // A press while waiting outranks delay expiry in the same cycle.
        if (btn_edge)          state_next = FAULT;
        else if (tick) begin
          if (delay == '0)     state_next = GO;
          else                 dec_delay  = 1'b1;
        end
      end
      GO: begin
        if (btn_edge) begin
          state_next   = DONE;
          latch_result = 1'b1;
          result_next  = CountIn;
        end else if (tick && CountIn == 8'hFF) begin
          state_next   = DONE;
          latch_result = 1'b1;
          result_next  = 8'hFF;
          set_timeout  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they settle together with it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      Led         <= 1'b0;
      CountEnable <= 1'b0;
      CountReset  <= 1'b1;
      Result      <= 8'h00;
      ResultValid <= 1'b0;
      FalseStart  <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      Led         <= (state_next == GO);
      // No pulse on the cycle that leaves GO: a press must not count that tick,
      // and a saturated counter must not wrap.
      CountEnable <= (state == GO) && (state_next == GO) && tick;
      CountReset  <= (state_next == IDLE) || (state_next == ARMED) || (state_next == FAULT);
      ResultValid <= (state_next == DONE);
      FalseStart  <= (state_next == FAULT);
      if (latch_result)              Result <= result_next;
      else if (state_next == FAULT)  Result <= 8'h00;
      if (set_timeout)               Timeout <= 1'b1;
      else if (load_delay)           Timeout <= 1'b0;
    end
  end

`ifdef BEST_TIME_EN
  logic [7:0] best;

  always_ff @(posedge Clock) begin
    if (Reset)
      best <= 8'hFF;
    else if (latch_result && !set_timeout && result_next < best)
      best <= result_next;
  end

  assign BestTime = best;
`else
  assign BestTime = 8'hFF;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl with an ideal 8-bit counter on CountIn.
// Uses fast parameters: TICK_DIV=4, DELAY_MIN_TICKS=2, RAND_BITS=4.
module tb_reaction_timer_ctrl;
  localparam int TD = 4, DM = 2, RB = 4;
`ifdef BEST_TIME_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic       Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Button = 1'b0;
  logic [7:0] CountIn = 8'h00;
  logic       CountEnable, CountReset, Led, ResultValid, FalseStart, Timeout;
  logic [7:0] Result, BestTime;

  logic [7:0] lfsr_m = 8'h01;
  logic [7:0] best_m = 8'hFF;
  int checks = 0, failures = 0, pulses = 0;
  bit cmp_en = 1'b0;

  reaction_timer_ctrl #(.TICK_DIV(TD), .DELAY_MIN_TICKS(DM), .RAND_BITS(RB)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Button(Button), .CountIn(CountIn),
    .CountEnable(CountEnable), .CountReset(CountReset), .Led(Led), .Result(Result),
    .ResultValid(ResultValid), .FalseStart(FalseStart), .Timeout(Timeout), .BestTime(BestTime));

  always #5 Clock = ~Clock;

  // Ideal downstream counter; it saturates, and the compare process separately flags any overflow attempt.
  always @(posedge Clock) begin
    if (CountReset !== 1'b0)                           CountIn <= 8'h00;
    else if (CountEnable === 1'b1 && CountIn != 8'hFF) CountIn <= CountIn + 8'h01;
  end

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifted every clock, seeded to 1 by Reset.
  always @(posedge Clock) begin
    if (Reset) lfsr_m <= 8'h01;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Per-cycle rules that must hold in every state.
  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("led_with_cntreset", Led & CountReset, 0);
      chk("enable_without_led", CountEnable & ~Led, 0);
      chk("valid_outputs", ResultValid & (Led | CountReset | FalseStart), 0);
      chk("fault_outputs", FalseStart & (~CountReset | Led | (Result != 8'h00)), 0);
      chk("timeout_without_valid", Timeout & ~ResultValid, 0);
      chk("counter_wrap", CountEnable & (CountIn == 8'hFF), 0);
      chk("best_time", BestTime, best_m);
      if (CountEnable === 1'b1) pulses++;
    end
  end

  // Call at a negedge. Returns the delay in ticks that the DUT should load.
  task automatic do_start(output int d);
    Start = 1'b1;
    d = DM + int'(lfsr_m[RB-1:0]);
    @(posedge Clock); #1;
    Start = 1'b0;
    pulses = 0;
  endtask

  task automatic wait_led(input int d);
    int n;
    n = 0;
    while (Led !== 1'b1 && n < 400) begin
      @(negedge Clock);
      n++;
    end
    // Cycles from the Start-accept edge to the edge where Led rose.
    chk_rng("led_delay", n - 1, 4 * d - 4, 4 * d + 4);
  endtask

  // Wait w cycles after Led, then press. Expected Result is the counter value
  // in the cycle the synchronised edge acts on, which is the third edge after the press.
  task automatic react(input int w, output logic [7:0] r);
    repeat (w) @(negedge Clock);
    Button = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    r = CountIn;
    @(posedge Clock); #1;
    chk("react_valid", ResultValid, 1);
    chk("react_result", Result, r);
    chk("react_led", Led, 0);
    chk("react_timeout", Timeout, 0);
    if (BEST_ON && r < best_m) best_m = r;
    @(negedge Clock);
    Button = 1'b0;
    repeat (4) @(negedge Clock);
    chk("done_hold", {ResultValid, Result}, {1'b1, r});
    chk_rng("count_frozen", int'(CountIn), int'(r), int'(r) + 1);
  endtask

  task automatic time_out();
    int n;
    n = 0;
    while (ResultValid !== 1'b1 && n < 1300) begin
      @(negedge Clock);
      n++;
    end
    chk("to_valid", ResultValid, 1);
    chk("to_result", Result, 8'hFF);
    chk("to_flag", Timeout, 1);
    repeat (12) @(negedge Clock);
    chk("to_pulses", pulses, 255);
    chk("to_no_wrap", CountIn, 8'hFF);
  endtask

  task automatic false_start();
    int d, k;
    logic [7:0] r;
    do_start(d);
    k = $urandom_range(0, 3);
    repeat (k + 1) @(negedge Clock);
    Button = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("fs_flag", FalseStart, 1);
    chk("fs_led", Led, 0);
    chk("fs_result", Result, 0);
    chk("fs_cntreset", CountReset, 1);
    @(negedge Clock);
    Button = 1'b0;
    repeat (80) @(negedge Clock);
    chk("fs_led_never", {Led, FalseStart}, 2'b01);
    do_start(d);
    chk("fs_restart", {FalseStart, Led, CountReset}, 3'b001);
    wait_led(d);
    react($urandom_range(1, 300), r);
  endtask

  initial begin
    logic [7:0] r;
    int d;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_led", Led, 0);
    chk("rst_en", CountEnable, 0);
    chk("rst_cntreset", CountReset, 1);
    chk("rst_result", Result, 0);
    chk("rst_valid", ResultValid, 0);
    chk("rst_fs", FalseStart, 0);
    chk("rst_timeout", Timeout, 0);
    chk("rst_best", BestTime, 8'hFF);
    @(negedge Clock);
    Reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge Clock);

    // Press 10 ticks after Led.
    do_start(d);
    wait_led(d);
    react(40, r);
    chk("lit_r10", r, 10);
    chk_rng("result_10", int'(Result), 9, 11);

    false_start();

    // Reset in the middle of GO.
    @(negedge Clock);
    do_start(d);
    wait_led(d);
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    best_m = 8'hFF;
    chk("midrst_outputs", {Led, CountEnable, CountReset, ResultValid}, 4'b0010);
    chk("midrst_best", BestTime, 8'hFF);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // Best-time sequence: 20, 12, then a timeout.
    do_start(d);
    wait_led(d);
    react(80, r);
    chk("lit_r20", r, 20);
    chk("best_after_20", BestTime, BEST_ON ? 8'd20 : 8'hFF);
    do_start(d);
    wait_led(d);
    react(48, r);
    chk("lit_r12", r, 12);
    chk("best_after_12", BestTime, BEST_ON ? 8'd12 : 8'hFF);
    do_start(d);
    wait_led(d);
    time_out();
    chk("best_after_to", BestTime, BEST_ON ? 8'd12 : 8'hFF);
    @(negedge Clock);
    do_start(d);
    chk("restart_clears_to", {Timeout, ResultValid}, 2'b00);
    wait_led(d);
    react($urandom_range(1, 300), r);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 2) == 0) false_start();
      else begin
        do_start(d);
        wait_led(d);
        react($urandom_range(1, 400), r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
